// File: rtl/riscv_mc_ctrl.sv
// ---------------------------------------------------------------------------
// riscv_mc_ctrl - multi-cycle control sequencer for an RV32I core.
//
// Each instruction moves through FETCH -> DECODE -> EXECUTE -> (MEM) -> (WB).
// The block drives the PC, instruction-register, register-file and shared
// memory-port strobes. Memory accesses use a memReq/memReady handshake that is
// guarded by a wait-state timeout. The block also counts retired instructions.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   opcode, funct3      fields of the instruction held in the IR
//   zero, lt, ltu       ALU compare flags used to resolve branches
//   memReady            memory completes the current access this cycle
//   memReq, memWe       memory request and its write qualifier
//   irWrite, regWrite   instruction-register load, register-file write
//   pcEn, pcSrc         PC update strobe and select (1 = PC+offset)
//   state, halted       debug view of the FSM, HALT indicator
//   illegal, busErr     sticky halt causes
//   retiredCount        retired-instruction counter (wraps)
//
// All outputs are decoded combinationally from the registered state and the
// current inputs, and are forced to zero while reset is high.
// ---------------------------------------------------------------------------
module riscv_mc_ctrl #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             zero,
    input  logic             lt,
    input  logic             ltu,
    input  logic             memReady,
    output logic             memReq,
    output logic             memWe,
    output logic             irWrite,
    output logic             regWrite,
    output logic             pcEn,
    output logic             pcSrc,
    output logic [2:0]       state,
    output logic             halted,
    output logic             illegal,
    output logic             busErr,
    output logic [CNT_W-1:0] retiredCount
);

    // A zero TIMEOUT still needs a legal one-bit counter.
    localparam int unsigned WAIT_W = (TIMEOUT > 32'd0) ? $clog2(TIMEOUT + 32'd1) : 1;
    localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(TIMEOUT);

    localparam logic [2:0] S_FETCH   = 3'd0;
    localparam logic [2:0] S_DECODE  = 3'd1;
    localparam logic [2:0] S_EXECUTE = 3'd2;
    localparam logic [2:0] S_MEM     = 3'd3;
    localparam logic [2:0] S_WB      = 3'd4;
    localparam logic [2:0] S_HALT    = 3'd5;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Branch condition resolution from funct3 and the ALU compare flags.
    function automatic logic branch_taken(
        input logic [2:0] f3,
        input logic       z,
        input logic       slt,
        input logic       sltu
    );
        logic t;
        case (f3)
            3'b000:  t = z;
            3'b001:  t = ~z;
            3'b100:  t = slt;
            3'b101:  t = ~slt;
            3'b110:  t = sltu;
            3'b111:  t = ~sltu;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    logic [2:0]        state_q,    state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  retired_q,  retired_d;
    logic              illegal_q,  illegal_d;
    logic              bus_err_q,  bus_err_d;

    logic              timeout_s;
    logic [WAIT_W-1:0] wait_inc_s;
    logic              is_store_s;

    // With TIMEOUT=0 the compare value is 0 and the counter never leaves 0,
    // so the timeout never fires; the counter saturates at the limit.
    assign timeout_s  = (TIMEOUT != 32'd0) && (wait_cnt_q == TIMEOUT_CNT);
    assign wait_inc_s = (wait_cnt_q == TIMEOUT_CNT) ? wait_cnt_q
                                                    : wait_cnt_q + {{(WAIT_W-1){1'b0}}, 1'b1};
    assign is_store_s = (opcode == OPC_STORE);

    // State register and all sequential bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
            retired_q  <= '0;
            illegal_q  <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            retired_q  <= retired_d;
            illegal_q  <= illegal_d;
            bus_err_q  <= bus_err_d;
        end
    end

    // Next-state logic, wait counter, sticky error flags and retire counter.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;              // cleared on any progress or state change
        illegal_d  = illegal_q;
        bus_err_d  = bus_err_q;
        retired_d  = retired_q + {{(CNT_W-1){1'b0}}, pcEn};

        case (state_q)
            S_FETCH: begin
                // memReady takes priority over an expiring timeout
                if (memReady) begin
                    state_d = S_DECODE;
                end else if (timeout_s) begin
                    state_d   = S_HALT;
                    bus_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_inc_s;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP,
                    OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: begin
                        state_d = S_EXECUTE;
                    end
                    OPC_BRANCH: begin
                        if ((funct3 == 3'b010) || (funct3 == 3'b011)) begin
                            state_d   = S_HALT;
                            illegal_d = 1'b1;
                        end else begin
                            state_d = S_EXECUTE;
                        end
                    end
                    OPC_SYSTEM: begin
                        state_d = S_HALT;
                    end
                    default: begin
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_EXECUTE: begin
                case (opcode)
                    OPC_BRANCH:          state_d = S_FETCH;
                    OPC_LOAD, OPC_STORE: state_d = S_MEM;
                    default:             state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (memReady) begin
                    if (is_store_s) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout_s) begin
                    state_d   = S_HALT;
                    bus_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_inc_s;
                end
            end
            S_WB: begin
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                // unreachable encodings park safely
                state_d = S_HALT;
            end
        endcase
    end

    // Output decode from registered state plus same-cycle inputs.
    always_comb begin
        memReq       = 1'b0;
        memWe        = 1'b0;
        irWrite      = 1'b0;
        regWrite     = 1'b0;
        pcEn         = 1'b0;
        pcSrc        = 1'b0;
        halted       = 1'b0;
        state        = 3'd0;
        illegal      = 1'b0;
        busErr       = 1'b0;
        retiredCount = '0;

        if (reset) begin
            memReq = 1'b0;
        end else begin
            state        = state_q;
            illegal      = illegal_q;
            busErr       = bus_err_q;
            retiredCount = retired_q;
            case (state_q)
                S_FETCH: begin
                    memReq  = 1'b1;
                    irWrite = memReady;
                end
                S_DECODE: begin
                    memReq = 1'b0;
                end
                S_EXECUTE: begin
                    if (opcode == OPC_BRANCH) begin
                        pcEn  = 1'b1;
                        pcSrc = branch_taken(funct3, zero, lt, ltu);
                    end else begin
                        pcEn = 1'b0;
                    end
                end
                S_MEM: begin
                    memReq = 1'b1;
                    memWe  = is_store_s;
                    pcEn   = memReady & is_store_s;
                end
                S_WB: begin
                    regWrite = 1'b1;
                    pcEn     = 1'b1;
                    pcSrc    = (opcode == OPC_JAL) || (opcode == OPC_JALR);
                end
                S_HALT: begin
                    halted = 1'b1;
                end
                default: begin
                    halted = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
module tb_riscv_mc_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       zero, lt, ltu, mem_ready;
    logic       mem_req, mem_we, ir_write, reg_write, pc_en, pc_src;
    logic [2:0] state_o;
    logic       halted, illegal, bus_err;
    logic [7:0] retired;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic        rdy;
        logic [11:0] e;
    } step_t;

    logic [11:0] exp_q[$];
    logic [11:0] obs;
    assign obs = {state_o, mem_req, mem_we, ir_write, reg_write, pc_en, pc_src,
                  halted, illegal, bus_err};

    riscv_mc_ctrl #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
        .zero(zero), .lt(lt), .ltu(ltu), .memReady(mem_ready),
        .memReq(mem_req), .memWe(mem_we), .irWrite(ir_write),
        .regWrite(reg_write), .pcEn(pc_en), .pcSrc(pc_src), .state(state_o),
        .halted(halted), .illegal(illegal), .busErr(bus_err),
        .retiredCount(retired)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // expected vector: state, memReq, memWe, irWrite, regWrite, pcEn, pcSrc, halted, illegal, busErr
    function automatic logic [11:0] ev(input logic [2:0] st, input logic mr, mw, irw, rw,
                                       pe, ps, h, il, be);
        return {st, mr, mw, irw, rw, pe, ps, h, il, be};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] e;
        reset = 1'b1;
        mem_ready = 1'b1;
        opcode = 7'b0110011;
        exp_q.push_back(12'd0);
        @(negedge clk);
        e = exp_q.pop_front();
        n_vec++;
        if (obs !== e) begin n_err++; $display("FAIL reset_outs got=%b exp=%b", obs, e); end
        n_vec++;
        if (retired !== 8'd0) begin n_err++; $display("FAIL reset_cnt got=%0d exp=0", retired); end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // OP (pcSrc=0) and JAL (pcSrc=1): F, D, E, WB, back in F
    task automatic test_alu_jal();
        logic [11:0] e;
        logic [6:0]  opc[2];
        logic        src[2];
        step_t       steps[$];
        opc[0] = 7'b0110011; src[0] = 1'b0;
        opc[1] = 7'b1101111; src[1] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            do_reset();
            opcode = opc[k];
            funct3 = 3'd0;
            steps.delete();
            steps.push_back('{1'b1, ev(3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)});
            steps.push_back('{1'b1, ev(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)});
            steps.push_back('{1'b1, ev(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)});
            steps.push_back('{1'b1, ev(3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, src[k], 1'b0, 1'b0, 1'b0)});
            steps.push_back('{1'b1, ev(3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)});
            foreach (steps[i]) begin
                mem_ready = steps[i].rdy;
                exp_q.push_back(steps[i].e);
                @(negedge clk);
                e = exp_q.pop_front();
                n_vec++;
                if (obs !== e) begin n_err++; $display("FAIL alu_jal op%0d cyc%0d got=%b exp=%b", k, i, obs, e); end
                @(posedge clk); #1;
            end
            n_vec++;
            if (retired !== 8'd1) begin n_err++; $display("FAIL alu_jal_cnt got=%0d exp=1", retired); end
        end
    endtask

    // back-to-back branches: F, D, E(pcEn, pcSrc=taken)
    task automatic test_branch();
        logic [11:0] e;
        logic [2:0]  f3[6];
        logic [2:0]  flg[6];   // {zero, lt, ltu}
        logic        tk[6];
        step_t       steps[$];
        f3[0] = 3'b000; flg[0] = 3'b100; tk[0] = 1'b1;
        f3[1] = 3'b001; flg[1] = 3'b100; tk[1] = 1'b0;
        f3[2] = 3'b100; flg[2] = 3'b010; tk[2] = 1'b1;
        f3[3] = 3'b101; flg[3] = 3'b010; tk[3] = 1'b0;
        f3[4] = 3'b110; flg[4] = 3'b000; tk[4] = 1'b0;
        f3[5] = 3'b111; flg[5] = 3'b000; tk[5] = 1'b1;
        do_reset();
        opcode = 7'b1100011;
        for (int k = 0; k < 6; k++) begin
            funct3 = f3[k];
            {zero, lt, ltu} = flg[k];
            steps.delete();
            steps.push_back('{1'b1, ev(3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)});
            steps.push_back('{1'b1, ev(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)});
            steps.push_back('{1'b1, ev(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, tk[k], 1'b0, 1'b0, 1'b0)});
            foreach (steps[i]) begin
                mem_ready = steps[i].rdy;
                exp_q.push_back(steps[i].e);
                @(negedge clk);
                e = exp_q.pop_front();
                n_vec++;
                if (obs !== e) begin n_err++; $display("FAIL branch f3=%b cyc%0d got=%b exp=%b", f3[k], i, obs, e); end
                @(posedge clk); #1;
            end
        end
        zero = 1'b0; lt = 1'b0; ltu = 1'b0;
        n_vec++;
        if (retired !== 8'd6) begin n_err++; $display("FAIL branch_cnt got=%0d exp=6", retired); end
    endtask

    // LOAD with 3 wait states in MEM, then STORE with 1 wait state
    task automatic test_mem();
        logic [11:0] e;
        step_t       steps[$];
        do_reset();
        opcode = 7'b0000011;
        funct3 = 3'b010;
        steps.push_back('{1'b1, ev(3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)});
        steps.push_back('{1'b1, ev(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)});
        steps.push_back('{1'b1, ev(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)});
        for (int w = 0; w < 3; w++)
            steps.push_back('{1'b0, ev(3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)});
        steps.push_back('{1'b1, ev(3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)});
        steps.push_back('{1'b1, ev(3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)});
        foreach (steps[i]) begin
            mem_ready = steps[i].rdy;
            exp_q.push_back(steps[i].e);
            @(negedge clk);
            e = exp_q.pop_front();
            n_vec++;
            if (obs !== e) begin n_err++; $display("FAIL load cyc%0d got=%b exp=%b", i, obs, e); end
            @(posedge clk); #1;
        end
        // now back in FETCH after 8 cycles
        opcode = 7'b0100011;
        steps.delete();
        steps.push_back('{1'b1, ev(3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)});
        steps.push_back('{1'b1, ev(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)});
        steps.push_back('{1'b1, ev(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)});
        steps.push_back('{1'b0, ev(3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)});
        steps.push_back('{1'b1, ev(3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)});
        steps.push_back('{1'b1, ev(3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)});
        foreach (steps[i]) begin
            mem_ready = steps[i].rdy;
            exp_q.push_back(steps[i].e);
            @(negedge clk);
            e = exp_q.pop_front();
            n_vec++;
            if (obs !== e) begin n_err++; $display("FAIL store cyc%0d got=%b exp=%b", i, obs, e); end
            @(posedge clk); #1;
        end
        n_vec++;
        if (retired !== 8'd2) begin n_err++; $display("FAIL mem_cnt got=%0d exp=2", retired); end
    endtask

    // FETCH timeout with TIMEOUT=4, reset recovery, and ready arriving on the limit cycle
    task automatic test_timeout();
        logic [11:0] e;
        step_t       steps[$];
        do_reset();
        opcode = 7'b0110011;
        for (int w = 0; w < 5; w++)
            steps.push_back('{1'b0, ev(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)});
        steps.push_back('{1'b0, ev(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1)});
        steps.push_back('{1'b1, ev(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1)});
        foreach (steps[i]) begin
            mem_ready = steps[i].rdy;
            exp_q.push_back(steps[i].e);
            @(negedge clk);
            e = exp_q.pop_front();
            n_vec++;
            if (obs !== e) begin n_err++; $display("FAIL timeout cyc%0d got=%b exp=%b", i, obs, e); end
            @(posedge clk); #1;
        end
        do_reset();
        steps.delete();
        for (int w = 0; w < 4; w++)
            steps.push_back('{1'b0, ev(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)});
        steps.push_back('{1'b1, ev(3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)});
        steps.push_back('{1'b0, ev(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)});
        foreach (steps[i]) begin
            mem_ready = steps[i].rdy;
            exp_q.push_back(steps[i].e);
            @(negedge clk);
            e = exp_q.pop_front();
            n_vec++;
            if (obs !== e) begin n_err++; $display("FAIL ready_wins cyc%0d got=%b exp=%b", i, obs, e); end
            @(posedge clk); #1;
        end
    endtask

    // illegal opcode, reserved branch funct3, and SYSTEM halts
    task automatic test_illegal();
        logic [11:0] e;
        logic [6:0]  opc[3];
        logic [2:0]  f3[3];
        logic        il[3];
        step_t       steps[$];
        opc[0] = 7'b1111111; f3[0] = 3'b000; il[0] = 1'b1;
        opc[1] = 7'b1100011; f3[1] = 3'b010; il[1] = 1'b1;
        opc[2] = 7'b1110011; f3[2] = 3'b000; il[2] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            do_reset();
            opcode = opc[k];
            funct3 = f3[k];
            steps.delete();
            steps.push_back('{1'b1, ev(3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)});
            steps.push_back('{1'b1, ev(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)});
            steps.push_back('{1'b1, ev(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, il[k], 1'b0)});
            steps.push_back('{1'b1, ev(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, il[k], 1'b0)});
            foreach (steps[i]) begin
                mem_ready = steps[i].rdy;
                exp_q.push_back(steps[i].e);
                @(negedge clk);
                e = exp_q.pop_front();
                n_vec++;
                if (obs !== e) begin n_err++; $display("FAIL illegal op%0d cyc%0d got=%b exp=%b", k, i, obs, e); end
                @(posedge clk); #1;
            end
            n_vec++;
            if (retired !== 8'd0) begin n_err++; $display("FAIL illegal_cnt got=%0d exp=0", retired); end
        end
    endtask

    // reset during MEM of a LOAD aborts with no regWrite/pcEn
    task automatic test_reset_mid();
        logic [11:0] e;
        step_t       steps[$];
        do_reset();
        opcode = 7'b0000011;
        steps.push_back('{1'b1, ev(3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)});
        steps.push_back('{1'b1, ev(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)});
        steps.push_back('{1'b1, ev(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)});
        steps.push_back('{1'b0, ev(3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)});
        foreach (steps[i]) begin
            mem_ready = steps[i].rdy;
            exp_q.push_back(steps[i].e);
            @(negedge clk);
            e = exp_q.pop_front();
            n_vec++;
            if (obs !== e) begin n_err++; $display("FAIL reset_mid cyc%0d got=%b exp=%b", i, obs, e); end
            @(posedge clk); #1;
        end
        reset = 1'b1;
        mem_ready = 1'b1;
        exp_q.push_back(12'd0);
        @(negedge clk);
        e = exp_q.pop_front();
        n_vec++;
        if (obs !== e) begin n_err++; $display("FAIL reset_mid_hold got=%b exp=%b", obs, e); end
        @(posedge clk); #1;
        reset = 1'b0;
        mem_ready = 1'b0;
        exp_q.push_back(ev(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        e = exp_q.pop_front();
        n_vec++;
        if (obs !== e) begin n_err++; $display("FAIL reset_mid_after got=%b exp=%b", obs, e); end
        n_vec++;
        if (retired !== 8'd0) begin n_err++; $display("FAIL reset_mid_cnt got=%0d exp=0", retired); end
        @(posedge clk); #1;
    endtask

    // retiredCount wraps at 2^CNT_W (CNT_W=8 here)
    task automatic test_wrap();
        do_reset();
        opcode = 7'b0110011;
        mem_ready = 1'b1;
        repeat (255 * 4) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (retired !== 8'd255) begin n_err++; $display("FAIL wrap_255 got=%0d exp=255", retired); end
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (retired !== 8'd0 || state_o !== 3'd0) begin
            n_err++;
            $display("FAIL wrap_0 got cnt=%0d st=%0d exp cnt=0 st=0", retired, state_o);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1;
        opcode = 7'd0; funct3 = 3'd0;
        zero = 1'b0; lt = 1'b0; ltu = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_alu_jal();
        test_branch();
        test_mem();
        test_timeout();
        test_illegal();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
